scan_sched: RTL and testbench



---
 rtl/scan_sched.sv | 127 ++++++++++++
 tb/tb_scan_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_sched.sv
// scan_sched: column-scan sequencer driving the column shift register SEL, blanking and frame-swap handshake.
// Define SCAN_DIMMING_EN to add the bright[3:0] input and PWM dimming during each column's dwell.
module scan_sched #(
  parameter int N_COLS    = 24,
  parameter int DWELL_CYC = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic                      clk,
  input  logic                      CLR,
  input  logic                      en,
  input  logic                      swap_ack,
`ifdef SCAN_DIMMING_EN
  input  logic [3:0]                bright,
`endif
  output logic [1:0]                sel,
  output logic                      blank,
  output logic [$clog2(N_COLS)-1:0] col_idx,
  output logic                      frame_start,
  output logic                      frame_done,
  output logic                      swap_req
);

  localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int COL_W   = $clog2(N_COLS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(N_COLS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_BLANK     = 3'd2;
  localparam logic [2:0] S_DWELL     = 3'd3;
  localparam logic [2:0] S_SHIFT     = 3'd4;
  localparam logic [2:0] S_FRAME_END = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col_q;
  logic             fe_first;
  logic             dwell_blank;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (en) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_BLANK;
      S_BLANK:     if (cnt == '0) state_nxt = S_DWELL;
      S_DWELL: begin
        if (cnt == '0) state_nxt = (col_q == LAST_COL) ? S_FRAME_END : S_SHIFT;
      end
      S_SHIFT:     state_nxt = S_BLANK;
      // Dropping en wins over a simultaneous swap_ack.
      S_FRAME_END: begin
        if (!en)          state_nxt = S_IDLE;
        else if (swap_ack) state_nxt = S_LOAD;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      state    <= S_IDLE;
      cnt      <= '0;
      col_q    <= '0;
      fe_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      fe_first <= (state_nxt == S_FRAME_END) && (state != S_FRAME_END);
      if (state_nxt != state) begin
        case (state_nxt)
          S_BLANK: cnt <= BLANK_LAST;
          S_DWELL: cnt <= DWELL_LAST;
          default: cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state_nxt == S_LOAD || state_nxt == S_IDLE)
        col_q <= '0;
      else if (state == S_SHIFT)
        col_q <= col_q + COL_W'(1);
    end
  end

`ifdef SCAN_DIMMING_EN
  logic [3:0] pwm_cnt;
  logic [3:0] bright_q;

  // Brightness is captured once per column so a mid-dwell change cannot glitch the duty cycle.
  always_ff @(posedge clk) begin
    if (CLR) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
    end else if (state_nxt == S_DWELL && state != S_DWELL) begin
      pwm_cnt  <= '0;
      bright_q <= bright;
    end else if (state == S_DWELL) begin
      pwm_cnt  <= pwm_cnt + 4'd1;
    end
  end

  assign dwell_blank = (pwm_cnt >= bright_q);
`else
  assign dwell_blank = 1'b0;
`endif

  always_comb begin
    sel   = 2'b00;
    blank = 1'b1;
    case (state)
      S_LOAD:  sel   = 2'b01;
      S_SHIFT: sel   = 2'b10;
      S_DWELL: blank = dwell_blank;
      default: ;
    endcase
  end

  assign col_idx     = col_q;
  assign frame_start = (state == S_LOAD);
  assign frame_done  = fe_first;
  assign swap_req    = (state == S_FRAME_END);

endmodule

// File: tb/tb_scan_sched.sv
// Randomized self-checking bench for scan_sched; the reference model tracks time since LOAD and
// derives every expected output arithmetically from the frame timing rules.
module tb_scan_sched;

  localparam int N         = 24;
  localparam int D         = 16;
  localparam int B         = 2;
  localparam int P         = B + D + 1;
  localparam int FRAME_LEN = N * P;

  logic       clk = 1'b0;
  logic       CLR;
  logic       en;
  logic       swap_ack;
  logic [1:0] sel;
  logic       blank;
  logic [4:0] col_idx;
  logic       frame_start;
  logic       frame_done;
  logic       swap_req;
`ifdef SCAN_DIMMING_EN
  logic [3:0] bright;
  int         m_bright;
  bit         bright_rand;
`endif

  int vectors     = 0;
  int miscompares = 0;

  bit          m_idle;
  bit          m_reset_idle;
  int          m_t;
  logic [23:0] q;
  int          shifts_seen;

  scan_sched dut (
    .clk         (clk),
    .CLR         (CLR),
    .en          (en),
    .swap_ack    (swap_ack),
`ifdef SCAN_DIMMING_EN
    .bright      (bright),
`endif
    .sel         (sel),
    .blank       (blank),
    .col_idx     (col_idx),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .swap_req    (swap_req)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // Model advance across one rising edge, given the inputs held across it.
  task automatic modelStep(input bit c, input bit e, input bit a);
    if (c) begin
      m_idle       = 1'b1;
      m_reset_idle = 1'b1;
    end else if (m_idle) begin
      if (e) begin
        m_idle       = 1'b0;
        m_reset_idle = 1'b0;
        m_t          = 0;
      end
    end else if (m_t >= FRAME_LEN) begin
      if (!e) begin
        m_idle       = 1'b1;
        m_reset_idle = 1'b0;
      end else if (a) begin
        m_t = 0;
      end else begin
        m_t++;
      end
    end else begin
      m_t++;
    end
`ifdef SCAN_DIMMING_EN
    if (!m_idle && m_t > 0 && m_t < FRAME_LEN && ((m_t - 1) % P) == B)
      m_bright = int'(bright);
`endif
  endtask

  task automatic applyStimulus(input bit c, input bit e, input bit a);
    int   u;
    int   r;
    int   ecol;
    int   esel;
    bit   eblank;
    bit   efs;
    bit   efd;
    bit   esr;
    bit   chk_col;
    bit   dwell;
    @(negedge clk);
    esel = 0; eblank = 1'b1; efs = 1'b0; efd = 1'b0; esr = 1'b0;
    ecol = 0; chk_col = 1'b0; dwell = 1'b0;
    if (m_idle) begin
      chk_col = m_reset_idle;
    end else if (m_t == 0) begin
      esel = 1; efs = 1'b1; chk_col = 1'b1;
    end else if (m_t < FRAME_LEN) begin
      u = m_t - 1;
      ecol = u / P;
      r = u % P;
      chk_col = 1'b1;
      if (r >= B && r < B + D) begin
        dwell = 1'b1;
`ifdef SCAN_DIMMING_EN
        eblank = ((r - B) >= m_bright);
`else
        eblank = 1'b0;
`endif
      end else if (r == B + D) begin
        esel = 2;
      end
    end else begin
      ecol = N - 1; chk_col = 1'b1; esr = 1'b1;
      efd = (m_t == FRAME_LEN);
    end

    checkOutput("sel", 32'(sel), 32'(esel));
    checkOutput("blank", 32'(blank), 32'(eblank));
    checkOutput("frame_start", 32'(frame_start), 32'(efs));
    checkOutput("frame_done", 32'(frame_done), 32'(efd));
    checkOutput("swap_req", 32'(swap_req), 32'(esr));
    if (chk_col) checkOutput("col_idx", 32'(col_idx), 32'(ecol));
    if (dwell)   checkOutput("q_onehot", 32'(q), 32'b1 << ecol);
    if (efd)     checkOutput("shift_count", 32'(shifts_seen), 32'(N - 1));

    // Paired column shift register follows whatever SEL the DUT drives this cycle.
    if (sel == 2'b01) begin
      q = 24'd1;
      shifts_seen = 0;
    end else if (sel == 2'b10) begin
      q = q << 1;
      shifts_seen++;
    end

    CLR = c; en = e; swap_ack = a;
`ifdef SCAN_DIMMING_EN
    if (bright_rand) bright = 4'($urandom_range(0, 15));
`endif
    modelStep(c, e, a);
  endtask

  initial begin
    CLR = 1'b1; en = 1'b0; swap_ack = 1'b0;
`ifdef SCAN_DIMMING_EN
    bright = 4'd4; m_bright = 0; bright_rand = 1'b0;
`endif
    m_idle = 1'b1; m_reset_idle = 1'b1; m_t = 0;
    q = '0; shifts_seen = 0;
    repeat (2) @(posedge clk);

    repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

    repeat (2 * FRAME_LEN + 20) applyStimulus(1'b0, 1'b1, 1'b1);

    // Hold off the swap for 10 cycles of FRAME_END.
`ifdef SCAN_DIMMING_EN
    bright = 4'd0;
`endif
    for (int i = 0; i < 2000 && !(!m_idle && m_t == FRAME_LEN + 10); i++)
      applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stall_reached", 32'(!m_idle && m_t == FRAME_LEN + 10), 32'd1);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1);

    // Drop en at column 5, with swap_ack high when the frame ends.
    for (int i = 0; i < 2000 && !(!m_idle && m_t == 1 + B + 5 * P); i++)
      applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("col5_reached", 32'(!m_idle && m_t == 1 + B + 5 * P), 32'd1);
    repeat (FRAME_LEN) applyStimulus(1'b0, 1'b0, 1'b1);

    // Reset in the middle of column 10's dwell, then restart.
    for (int i = 0; i < 2000 && !(!m_idle && m_t == 1 + B + 10 * P + D / 2); i++)
      applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("col10_reached", 32'(!m_idle && m_t == 1 + B + 10 * P + D / 2), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (60) applyStimulus(1'b0, 1'b1, 1'b1);

`ifdef SCAN_DIMMING_EN
    bright_rand = 1'b1;
`endif
    repeat (3000) begin
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
